// File: rtl/ps2_keyscan_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_keyscan_fifo                                            |
// | Description : PS/2 keyboard front end. Synchronises and filters the raw   |
// |               lines, deframes 11-bit frames, folds E0/F0 prefixes into    |
// |               make/break events and buffers them in a first-word-fall-    |
// |               through FIFO. Keeps the last two good bytes for a display.  |
// | Options     : define PS2_PARITY_CHECK_EN to reject odd-parity failures.   |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module ps2_keyscan_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rd_en,
    output logic [7:0]                    ev_code,
    output logic                          ev_brk,
    output logic                          ev_ext,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [1:0]                    err_code,
    output logic [15:0]                   xkey
);
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_fcnt_w = $clog2(FILTER_LEN) + 1;
    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic                r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic                r_filt, r_fall, r_fall_d;
    logic [c_fcnt_w-1:0] r_fcnt;
    state_t              r_state, w_next;
    logic [7:0]          r_shift;
    logic [2:0]          r_bitcnt;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                w_timeout, w_par_bad, w_done, w_err;
    logic [1:0]          w_code;
    logic                r_byte_done;
    logic [7:0]          r_byte;
    logic                r_ext, r_brk, r_push;
    logic [9:0]          r_push_data;
    logic [9:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wp, r_rp;
    logic [c_ptr_w:0]    r_count;
    logic                w_wr, w_rd;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_c_meta <= 1'b1; r_c_sync <= 1'b1;
            r_d_meta <= 1'b1; r_d_sync <= 1'b1;
        end else begin
            r_c_meta <= ps2c; r_c_sync <= r_c_meta;
            r_d_meta <= ps2d; r_d_sync <= r_d_meta;
        end
    end

    // Glitch filter on the clock; strobe and data sample on the filtered falling edge
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_filt <= 1'b1; r_fcnt <= '0; r_fall <= 1'b0; r_fall_d <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_c_sync == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_fcnt_w'(FILTER_LEN - 1)) begin
                r_filt   <= r_c_sync;
                r_fcnt   <= '0;
                r_fall   <= ~r_c_sync;
                r_fall_d <= r_d_sync;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Frame datapath: shift register, bit counter and inter-edge timeout counter
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_shift <= '0; r_bitcnt <= '0; r_tcnt <= '0;
        end else begin
            if (r_state == ST_IDLE || r_fall) r_tcnt <= '0;
            else                              r_tcnt <= r_tcnt + 1'b1;
            if (r_fall && r_state == ST_IDLE) r_bitcnt <= '0;
            if (r_fall && r_state == ST_DATA) begin
                r_shift  <= {r_fall_d, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    // Parity bit is held until the stop bit arrives
    always_ff @(posedge clk) begin
        if (!clr)                             r_par <= 1'b0;
        else if (r_fall && r_state == ST_PARITY) r_par <= r_fall_d;
    end
    assign w_par_bad = ~(^{r_shift, r_par});
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_timeout = (r_state != ST_IDLE) && !r_fall &&
                       (r_tcnt == c_tcnt_w'(TIMEOUT_CYCLES - 1));

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!clr) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Frame FSM next state and frame verdict
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        w_code = 2'b00;
        case (r_state)
            ST_IDLE:   if (r_fall && !r_fall_d) w_next = ST_DATA;
            ST_DATA:   if (r_fall && r_bitcnt == 3'd7) w_next = ST_PARITY;
            ST_PARITY: if (r_fall) w_next = ST_STOP;
            ST_STOP: begin
                if (r_fall) begin
                    w_next = ST_IDLE;
                    if (!r_fall_d) begin
                        w_err = 1'b1; w_code = 2'b10;
                    end else if (w_par_bad) begin
                        w_err = 1'b1; w_code = 2'b01;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            default:   w_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next = ST_IDLE;
            w_err  = 1'b1;
            w_code = 2'b11;
        end
    end

    // Register the frame verdict; err_code holds the last reason
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_byte_done <= 1'b0; r_byte <= '0; frame_err <= 1'b0; err_code <= 2'b00;
        end else begin
            r_byte_done <= w_done;
            frame_err   <= w_err;
            if (w_done) r_byte   <= r_shift;
            if (w_err)  err_code <= w_code;
        end
    end

    // Prefix folding into events, plus the two-byte display history
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_ext <= 1'b0; r_brk <= 1'b0; r_push <= 1'b0; r_push_data <= '0; xkey <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_byte_done) begin
                xkey <= {xkey[7:0], r_byte};
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_push_data <= {r_ext, r_brk, r_byte};
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end
            if (frame_err) begin
                r_ext <= 1'b0; r_brk <= 1'b0;
            end
        end
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
    assign w_rd  = rd_en && !empty;
    assign w_wr  = r_push && (!full || w_rd);

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_wp <= '0; r_rp <= '0; r_count <= '0; overflow <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
            if (r_push && full && !w_rd) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= r_push_data;
    end

    assign {ev_ext, ev_brk, ev_code} = empty ? 10'h000 : r_mem[r_rp];
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyscan_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ps2_keyscan_fifo                                         |
// | Description : Randomised self-checking bench for ps2_keyscan_fifo with a  |
// |               frame-level event model and per-cycle output comparison.    |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_ps2_keyscan_fifo;
    localparam int DEPTH = 4;
    localparam int FLEN  = 4;
    localparam int TMO   = 400;
    localparam int HALF  = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0, clr = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rd_en = 1'b0;
    logic [7:0]  ev_code;
    logic        ev_brk, ev_ext, empty, full, overflow, frame_err;
    logic [2:0]  count;
    logic [1:0]  err_code;
    logic [15:0] xkey;

    ps2_keyscan_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clr(clr), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en),
        .ev_code(ev_code), .ev_brk(ev_brk), .ev_ext(ev_ext), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .frame_err(frame_err), .err_code(err_code),
        .xkey(xkey)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Behavioural model: event queue, prefix flags, sticky overflow, byte history
    logic [9:0]  m_q[$];
    logic        m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_xkey = 16'h0;
    logic [1:0]  err_seen[$];
    bit          quiet = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_xkey = {m_xkey[7:0], b};
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_xkey = 16'h0;
    endtask

    // Per-cycle comparison while the DUT is settled; error pulses are logged always
    always @(negedge clk) begin
        if (frame_err) err_seen.push_back(err_code);
        if (quiet) begin
            chk("count", 32'(count), m_q.size());
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("head", {22'h0, ev_ext, ev_brk, ev_code}, (m_q.size() != 0) ? {22'h0, m_q[0]} : 32'h0);
            chk("xkey", 32'(xkey), 32'(m_xkey));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_err_idle", 32'(frame_err), 32'h0);
        end
    end

    task automatic send_bit(input logic b);
        ps2d = b;
        tick(HALF / 2);
        ps2c = 1'b0;
        tick(HALF);
        ps2c = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic check_errs(input int exp_n, input logic [1:0] exp_code);
        chk("err_pulses", err_seen.size(), exp_n);
        if (exp_n > 0 && err_seen.size() > 0) chk("err_code", 32'(err_seen[0]), 32'(exp_code));
        err_seen.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bad);
        logic p;
        p = (~^b) ^ par_flip;
        quiet = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(~stop_bad);
        ps2d = 1'b1;
        tick(FLEN + 12);
        if (stop_bad) begin
            check_errs(1, 2'b10); m_ext = 1'b0; m_brk = 1'b0;
        end else if (par_flip && PAR_EN) begin
            check_errs(1, 2'b01); m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            check_errs(0, 2'b00); model_byte(b);
        end
        quiet = 1'b1;
        tick(3);
    endtask

    task automatic pop();
        quiet = 1'b0;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        quiet = 1'b1;
        tick(2);
    endtask

    task automatic drain();
        while (m_q.size() != 0) pop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int sel;
        clr = 1'b0;
        tick(5);
        clr = 1'b1;
        tick(1);
        quiet = 1'b1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_err_code", 32'(err_code), 32'h0);
        chk("rst_xkey", 32'(xkey), 32'h0);
        tick(2);

        // Single good frame
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("lit_1c_xkey", 32'(xkey), 32'h001C);
        chk("lit_1c_head", {22'h0, ev_ext, ev_brk, ev_code}, 32'h01C);
        chk("lit_1c_count", 32'(count), 32'h1);
        pop();

        // Extended break sequence folds into one event
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("lit_e0f075_xkey", 32'(xkey), 32'hF075);
        chk("lit_e0f075_head", {22'h0, ev_ext, ev_brk, ev_code}, 32'h375);
        chk("lit_e0f075_count", 32'(count), 32'h1);
        drain();

        // Bad parity on 1C: rejected with the check, accepted without
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("lit_par_count", 32'(count), PAR_EN ? 32'h0 : 32'h1);
        drain();

        // Overflow on a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("lit_ovf_full", 32'(full), 32'h1);
        chk("lit_ovf_sticky", 32'(overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("lit_ovf_order", 32'(ev_code), i);
            pop();
        end
        chk("lit_ovf_empty", 32'(empty), 32'h1);

        // Timeout after a partial frame, then a clean frame
        quiet = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2d = 1'b1;
        tick(TMO + FLEN + 40);
        check_errs(1, 2'b11);
        m_ext = 1'b0; m_brk = 1'b0;
        quiet = 1'b1;
        tick(2);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("lit_29_head", 32'(ev_code), 32'h29);
        drain();

        // Randomised traffic
        for (int n = 0; n < 36; n++) begin
            sel = int'($urandom_range(0, 5));
            b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) pop();
        end

        // Reset in the middle of a frame
        quiet = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        clr = 1'b0;
        tick(3);
        clr = 1'b1;
        model_reset();
        err_seen.delete();
        tick(1);
        quiet = 1'b1;
        chk("lit_rst_count", 32'(count), 32'h0);
        chk("lit_rst_err_code", 32'(err_code), 32'h0);
        tick(2);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("lit_5a_head", {22'h0, ev_ext, ev_brk, ev_code}, 32'h05A);
        chk("lit_5a_count", 32'(count), 32'h1);
        quiet = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
